// File: rtl/buffer_pool_seq.sv
// Load/read sequencer in front of the banked BufferPool.
// Scatters a word stream round-robin over banks and reads whole rows back.
module buffer_pool_seq #(
  parameter  int X_MAC      = 4,
  parameter  int X_MESH     = 16,
  parameter  int ADDR_LEN   = 13,
  parameter  int DATA_LEN   = 32,
  localparam int BUFFER_NUM = X_MAC * X_MESH,
  localparam int BANK_W     = $clog2(BUFFER_NUM),
  localparam int DATAWIDTH  = BUFFER_NUM * DATA_LEN,
  localparam int ADDRWIDTH  = BUFFER_NUM * ADDR_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_start,
  input  logic [ADDR_LEN:0]     wr_rows,
  input  logic                  rd_start,
  input  logic [ADDR_LEN:0]     rd_rows,
  output logic                  busy,
  output logic                  wr_done,
  output logic                  rd_done,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_LEN-1:0]   s_data,
  output logic [DATAWIDTH-1:0]  pool_dina,
  output logic [ADDRWIDTH-1:0]  pool_addra,
  output logic [BUFFER_NUM-1:0] pool_wea,
  output logic [ADDRWIDTH-1:0]  pool_addrb,
  input  logic [DATAWIDTH-1:0]  pool_doutb,
  output logic                  m_valid,
  output logic [DATAWIDTH-1:0]  m_data
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READ
  } state_t;

  state_t              state;
  logic [ADDR_LEN:0]   rows_q;
  logic [ADDR_LEN:0]   wr_row;
  logic [ADDR_LEN:0]   rd_row;
  logic [BANK_W-1:0]   bank_idx;
  logic                issue;
  logic [ADDR_LEN-1:0] addra_q;
  logic [DATA_LEN-1:0] dina_q;

  logic last_bank;
  logic last_wr_row;
  logic last_rd_row;

  assign last_bank   = bank_idx == BANK_W'(BUFFER_NUM - 1);
  assign last_wr_row = wr_row == rows_q - 1'b1;
  assign last_rd_row = rd_row == rows_q - 1'b1;

  assign busy       = state != IDLE;
  assign s_ready    = state == LOAD;
  assign pool_dina  = {BUFFER_NUM{dina_q}};
  assign pool_addra = {BUFFER_NUM{addra_q}};
  assign pool_addrb = {BUFFER_NUM{rd_row[ADDR_LEN-1:0]}};
  assign m_data     = pool_doutb;

  // Phase FSM, bank/row counters and registered pool-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rows_q   <= '0;
      wr_row   <= '0;
      rd_row   <= '0;
      bank_idx <= '0;
      issue    <= 1'b0;
      addra_q  <= '0;
      dina_q   <= '0;
      pool_wea <= '0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      m_valid  <= 1'b0;
    end else begin
      pool_wea <= '0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      m_valid  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_start) begin
            rows_q   <= wr_rows;
            bank_idx <= '0;
            wr_row   <= '0;
            if (wr_rows == '0) wr_done <= 1'b1;
            else               state   <= LOAD;
          end else if (rd_start) begin
            rows_q <= rd_rows;
            rd_row <= '0;
            if (rd_rows == '0) begin
              rd_done <= 1'b1;
            end else begin
              state <= READ;
              issue <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (s_valid) begin
            pool_wea <= BUFFER_NUM'(1) << bank_idx;
            addra_q  <= wr_row[ADDR_LEN-1:0];
            dina_q   <= s_data;
            if (last_bank) begin
              bank_idx <= '0;
              wr_row   <= wr_row + 1'b1;
              if (last_wr_row) begin
                state   <= IDLE;
                wr_done <= 1'b1;
              end
            end else begin
              bank_idx <= bank_idx + 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            m_valid <= 1'b1;
            if (last_rd_row) begin
              issue   <= 1'b0;
              rd_done <= 1'b1;
            end else begin
              rd_row <= rd_row + 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_pool_seq.sv
// Directed bench for buffer_pool_seq with a behavioural BRAM pool.
// Inputs change and outputs are checked on the falling edge.
module tb_buffer_pool_seq;
  localparam int NB = 64;
  localparam int AL = 13;
  localparam int DL = 32;
  localparam int DW = NB * DL;
  localparam int AW = NB * AL;

  logic          clk = 0;
  logic          rst;
  logic          wr_start, rd_start;
  logic [AL:0]   wr_rows, rd_rows;
  logic          busy, wr_done, rd_done;
  logic          s_valid, s_ready;
  logic [DL-1:0] s_data;
  logic [DW-1:0] pool_dina;
  logic [AW-1:0] pool_addra;
  logic [NB-1:0] pool_wea;
  logic [AW-1:0] pool_addrb;
  logic [DW-1:0] pool_doutb;
  logic          m_valid;
  logic [DW-1:0] m_data;

  int n_chk = 0;
  int n_fail = 0;

  buffer_pool_seq dut (
    .clk(clk), .rst(rst),
    .wr_start(wr_start), .wr_rows(wr_rows),
    .rd_start(rd_start), .rd_rows(rd_rows),
    .busy(busy), .wr_done(wr_done), .rd_done(rd_done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .pool_dina(pool_dina), .pool_addra(pool_addra),
    .pool_wea(pool_wea), .pool_addrb(pool_addrb),
    .pool_doutb(pool_doutb),
    .m_valid(m_valid), .m_data(m_data)
  );

  always #5 clk = ~clk;

  logic [DL-1:0] mem [NB][8];

  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (pool_wea[k])
        mem[k][pool_addra[k*AL +: 3]] <= pool_dina[k*DL +: DL];
      pool_doutb[k*DL +: DL] <= mem[k][pool_addrb[k*AL +: 3]];
    end
  end

  task automatic do_load(input int rows, input bit toggle,
                         input bit also_rd, input int base,
                         input bit pulse_rd, output int done_cyc);
    int total, acc, cyc, pj;
    bit pa, v;
    logic [NB-1:0] ew;
    logic [AL-1:0] er;
    logic [DL-1:0] ed;
    total = rows * NB;
    acc = 0; pa = 0; pj = 0; done_cyc = -1;
    wr_start = 1; wr_rows = (AL+1)'(rows);
    rd_start = also_rd; rd_rows = 2;
    @(negedge clk);
    wr_start = 0; rd_start = 0;
    cyc = 1;
    forever begin
      ew = pa ? (NB'(1) << (pj % NB)) : '0;
      n_chk++;
      if (pool_wea !== ew) begin
        n_fail++;
        $display("FAIL wea cyc=%0d got=%h exp=%h", cyc, pool_wea, ew);
      end
      if (pa) begin
        er = AL'(pj / NB);
        ed = DL'(base + pj);
        n_chk++;
        if (pool_addra !== {NB{er}} || pool_dina !== {NB{ed}}) begin
          n_fail++;
          $display("FAIL wr_addr_data cyc=%0d addr=%h data=%h exp_row=%0d exp_data=%h",
                   cyc, pool_addra[AL-1:0], pool_dina[DL-1:0], er, ed);
        end
      end
      n_chk++;
      if (wr_done !== (pa && pj == total - 1)) begin
        n_fail++;
        $display("FAIL wr_done cyc=%0d got=%b", cyc, wr_done);
      end
      if (wr_done === 1'b1) done_cyc = cyc;
      n_chk++;
      if (s_ready !== (acc < total) || busy !== (acc < total)) begin
        n_fail++;
        $display("FAIL s_ready_busy cyc=%0d got=%b/%b exp=%b", cyc, s_ready, busy, acc < total);
      end
      n_chk++;
      if (m_valid !== 1'b0 || rd_done !== 1'b0) begin
        n_fail++;
        $display("FAIL no_read cyc=%0d m_valid=%b rd_done=%b exp=0", cyc, m_valid, rd_done);
      end
      if (acc == total || cyc > 4 * total + 10) break;
      v = toggle ? ((cyc % 2) == 1) : 1'b1;
      s_valid = v; s_data = DL'(base + acc); rd_start = pulse_rd;
      pa = v; pj = acc;
      if (v) acc++;
      @(negedge clk);
      cyc++;
    end
    s_valid = 0; rd_start = 0;
    n_chk++;
    if (acc != total) begin
      n_fail++;
      $display("FAIL load_timeout beats=%0d exp=%0d", acc, total);
    end
    @(negedge clk);
    n_chk++;
    if (s_ready !== 0 || busy !== 0 || pool_wea !== '0 || m_valid !== 0) begin
      n_fail++;
      $display("FAIL after_load got s_ready=%b busy=%b wea=%h m_valid=%b exp=0",
               s_ready, busy, pool_wea, m_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1; wr_start = 0; rd_start = 0; wr_rows = 0; rd_rows = 0;
    s_valid = 0; s_data = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, s_ready, wr_done, rd_done, m_valid} !== 5'b0 || pool_wea !== '0
        || pool_addra !== '0 || pool_addrb !== '0 || pool_dina !== '0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b s_ready=%b wea=%h exp=0", busy, s_ready, pool_wea);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_load_contig();
    int dc;
    do_load(2, 0, 0, 0, 0, dc);
    n_chk++;
    if (dc != 129) begin
      n_fail++;
      $display("FAIL load_contig_done_cycle got=%0d exp=129", dc);
    end
  endtask

  task automatic test_load_toggle();
    int dc;
    do_load(2, 1, 0, 0, 0, dc);
    n_chk++;
    if (dc != 256) begin
      n_fail++;
      $display("FAIL load_toggle_done_cycle got=%0d exp=256", dc);
    end
  endtask

  task automatic test_read();
    logic [DW-1:0] r0, r1;
    for (int k = 0; k < NB; k++) begin
      r0[k*DL +: DL] = DL'(k);
      r1[k*DL +: DL] = DL'(64 + k);
    end
    rd_start = 1; rd_rows = 2;
    @(negedge clk);
    rd_start = 0;
    n_chk++;
    if (m_valid !== 0 || busy !== 1 || pool_addrb !== '0) begin
      n_fail++;
      $display("FAIL read_c1 m_valid=%b busy=%b addrb=%0d exp 0/1/0", m_valid, busy, pool_addrb[AL-1:0]);
    end
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1 || rd_done !== 0 || m_data !== r0
        || pool_addrb !== {NB{AL'(1)}}) begin
      n_fail++;
      $display("FAIL read_row0 m_valid=%b rd_done=%b d0=%0d d63=%0d exp 1/0/0/63",
               m_valid, rd_done, m_data[DL-1:0], m_data[63*DL +: DL]);
    end
    @(negedge clk);
    n_chk++;
    if (m_valid !== 1 || rd_done !== 1 || busy !== 1 || m_data !== r1) begin
      n_fail++;
      $display("FAIL read_row1 m_valid=%b rd_done=%b busy=%b d0=%0d exp 1/1/1/64",
               m_valid, rd_done, busy, m_data[DL-1:0]);
    end
    @(negedge clk);
    n_chk++;
    if (m_valid !== 0 || rd_done !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL read_end m_valid=%b rd_done=%b busy=%b exp 0", m_valid, rd_done, busy);
    end
  endtask

  task automatic test_write_priority();
    int dc;
    do_load(1, 0, 1, 500, 1, dc);
    repeat (4) begin
      @(negedge clk);
      n_chk++;
      if (m_valid !== 0 || rd_done !== 0 || busy !== 0) begin
        n_fail++;
        $display("FAIL prio_no_read m_valid=%b rd_done=%b busy=%b exp 0", m_valid, rd_done, busy);
      end
    end
  endtask

  task automatic test_zero_rows();
    wr_start = 1; wr_rows = 0;
    @(negedge clk);
    wr_start = 0;
    n_chk++;
    if (wr_done !== 1 || busy !== 0 || pool_wea !== '0) begin
      n_fail++;
      $display("FAIL zero_wr done=%b busy=%b wea=%h exp 1/0/0", wr_done, busy, pool_wea);
    end
    @(negedge clk);
    n_chk++;
    if (wr_done !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL zero_wr_after done=%b busy=%b exp 0", wr_done, busy);
    end
    rd_start = 1; rd_rows = 0;
    @(negedge clk);
    rd_start = 0;
    n_chk++;
    if (rd_done !== 1 || busy !== 0 || m_valid !== 0) begin
      n_fail++;
      $display("FAIL zero_rd done=%b busy=%b m_valid=%b exp 1/0/0", rd_done, busy, m_valid);
    end
    @(negedge clk);
    n_chk++;
    if (rd_done !== 0 || busy !== 0 || m_valid !== 0) begin
      n_fail++;
      $display("FAIL zero_rd_after done=%b busy=%b m_valid=%b exp 0", rd_done, busy, m_valid);
    end
  endtask

  task automatic test_reset_abort();
    int dc;
    wr_start = 1; wr_rows = 1;
    @(negedge clk);
    wr_start = 0;
    for (int i = 0; i <= 10; i++) begin
      s_valid = 1; s_data = DL'(i);
      @(negedge clk);
    end
    s_valid = 0;
    n_chk++;
    if (pool_wea !== (NB'(1) << 10)) begin
      n_fail++;
      $display("FAIL abort_pre_wea got=%h exp=%h", pool_wea, NB'(1) << 10);
    end
    rst = 1;
    #1;
    n_chk++;
    if (pool_wea !== '0 || s_ready !== 0 || wr_done !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL abort_async wea=%h s_ready=%b wr_done=%b busy=%b exp 0",
               pool_wea, s_ready, wr_done, busy);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_chk++;
    if (wr_done !== 0 || busy !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done wr_done=%b busy=%b exp 0", wr_done, busy);
    end
    do_load(1, 0, 0, 900, 0, dc);
    n_chk++;
    if (dc != 65) begin
      n_fail++;
      $display("FAIL abort_restart_done_cycle got=%0d exp=65", dc);
    end
  endtask

  initial begin
    test_reset();
    test_load_contig();
    test_load_toggle();
    test_read();
    test_write_priority();
    test_zero_rows();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
